// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson ring sequencer: FSM state encoding,
// default ring size/step-counter width and the legal-ring-pattern test.
package johnson_pkg;

    typedef enum logic [1:0] {
        JS_IDLE = 2'd0,
        JS_RUN  = 2'd1,
        JS_HOLD = 2'd2
    } js_state_t;

    localparam int JS_N      = 4;
    localparam int JS_STEP_W = $clog2(2 * JS_N);
    localparam int JS_MAX_W  = 32;

    // A Johnson pattern has at most one adjacent-bit transition; n is the ring width.
    function automatic logic js_legal(input logic [JS_MAX_W-1:0] ph, input int n);
        int trans;
        trans = 0;
        for (int i = 0; i < JS_MAX_W - 1; i++) begin
            if ((i < n - 1) && (ph[i] != ph[i+1])) begin
                trans++;
            end
        end
        return (trans <= 1);
    endfunction

endpackage

// File: rtl/johnson_ring.sv
// N-stage Johnson (twisted-ring) register: shifts toward bit 0 and feeds the
// inverted LSB back into the MSB. Clear wins over step enable.
module johnson_ring #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = {~q_q[0], q_q[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run controller for the Johnson ring: 2N*cycles steps per request, hold pause,
// done pulse. Optional illegal-pattern checker under JOHNSON_SEQ_ILLEGAL_CHK_EN.
module johnson_seq_ctrl
    import johnson_pkg::*;
#(
    parameter int N     = JS_N,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    input  logic             hold,
    output logic [N-1:0]     phase,
    output logic             phase_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int STEP_W = (N == JS_N) ? JS_STEP_W : $clog2(2 * N);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(2 * N - 1);

    js_state_t          state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ring_clr;
    logic               ring_en;
    logic               illegal;

    johnson_ring #(.N(N)) u_ring (
        .clk (clk),
        .rst (rst),
        .clr (ring_clr),
        .en  (ring_en),
        .q   (phase)
    );

`ifdef JOHNSON_SEQ_ILLEGAL_CHK_EN
    logic err_q, err_d;

    assign illegal = !js_legal(JS_MAX_W'(phase), N);

    always_comb begin
        err_d = err_q;
        if ((state_q == JS_IDLE) && start) begin
            err_d = 1'b0;
        end
        if (illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

    // rem == 0 while active marks the settle cycle after the final step:
    // the ring shows 0 with busy still high, then done follows.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        step_d   = step_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ring_clr = 1'b0;
        ring_en  = 1'b0;
        case (state_q)
            JS_IDLE: begin
                if (start) begin
                    if (cycles != '0) begin
                        rem_d    = cycles;
                        step_d   = '0;
                        ring_clr = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = JS_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            JS_RUN, JS_HOLD: begin
                if (hold) begin
                    state_d = JS_HOLD;
                end else if (rem_q == '0) begin
                    state_d = JS_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = JS_RUN;
                    ring_en = 1'b1;
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        rem_d  = rem_q - CNT_W'(1);
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            default: begin
                state_d = JS_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // A corrupted ring restarts its period; the rotation count is kept.
        if (illegal) begin
            ring_clr = 1'b1;
            step_d   = '0;
            if (state_q != JS_IDLE) begin
                rem_d = rem_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= JS_IDLE;
            rem_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // busy equals "state is RUN or HOLD"; a HOLD cycle with hold low is a stepping cycle.
    assign phase_valid = busy_q && !hold;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: per-cycle expected words {err,busy,done,phase_valid,phase}
// queued per run and compared at the falling edge.
module tb_johnson_seq_ctrl;

    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int W     = N + 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] cycles;
    logic             hold;
    logic [N-1:0]     phase;
    logic             phase_valid;
    logic             busy;
    logic             done;
    logic             err;

    logic [W-1:0] exp_q[$];
    int vectors;
    int miscompares;

    johnson_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cycles      (cycles),
        .hold        (hold),
        .phase       (phase),
        .phase_valid (phase_valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] obs();
        return {err, busy, done, phase_valid, phase};
    endfunction

    // Johnson pattern after j steps from all-zero.
    function automatic logic [N-1:0] jpat(input int j);
        logic [N-1:0] ones;
        int k;
        if (j <= N) begin
            ones = N'((1 << j) - 1);
            return ones << (N - j);
        end
        k = 2 * N - j;
        return N'((1 << k) - 1);
    endfunction

    function automatic logic [W-1:0] word(input logic b, input logic d, input logic pv,
                                          input logic [N-1:0] ph);
        return {1'b0, b, d, pv, ph};
    endfunction

    function automatic logic in_hold(input int t, input int ha, input int hl);
        return (hl > 0) && (t >= ha) && (t < ha + hl);
    endfunction

    // Expected per-interval outputs of one run, starting with the start interval.
    task automatic push_run(input int c, input int ha, input int hl);
        int total;
        int s;
        total = 2 * N * c;
        s = 0;
        exp_q.push_back(word(1'b0, 1'b0, 1'b0, '0));
        if (c != 0) begin
            for (int t = 1; t < 1000; t++) begin
                logic h;
                h = in_hold(t, ha, hl);
                exp_q.push_back(word(1'b1, 1'b0, !h, jpat(s % (2 * N))));
                if (!h) begin
                    if (s < total) s++;
                    else break;
                end
            end
        end
        exp_q.push_back(word(1'b0, 1'b1, 1'b0, '0));
    endtask

    // Drive one run (start at interval 0, hold window, optional stray start) and score it.
    task automatic run(input int c, input int ha, input int hl, input int stray_t);
        int len;
        int busy_cnt;
        int done_cnt;
        int exp_busy;
        push_run(c, ha, hl);
        len = exp_q.size();
        busy_cnt = 0;
        done_cnt = 0;
        for (int t = 0; t < len; t++) begin
            @(posedge clk);
            #1;
            start  = (t == 0) || (t == stray_t);
            cycles = (t == 0) ? CNT_W'(c) : CNT_W'(7);
            hold   = in_hold(t, ha, hl);
            @(negedge clk);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            check($sformatf("run c=%0d t=%0d", c, t), obs(), exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        hold  = 1'b0;
        if (c == 0) exp_busy = 0;
        else exp_busy = 2 * N * c + 1 + ((hl > 0 && ha == 0) ? hl - 1 : hl);
        check($sformatf("busy_len c=%0d", c), W'(busy_cnt), W'(exp_busy));
        check($sformatf("done_cnt c=%0d", c), W'(done_cnt), W'(1));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        start  = 1'b0;
        cycles = '0;
        hold   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset", obs(), '0);

        run(1, 0, 0, -1);
        run(3, 10, 5, -1);
        run(0, 0, 0, -1);
        run(2, 0, 0, 6);
        run(1, 0, 3, -1);
        run(1, 4, 1, -1);
        for (int r = 0; r < 3; r++) begin
            run($urandom_range(1, 3), $urandom_range(2, 8), $urandom_range(0, 4), -1);
        end

        // Reset mid-run: cycles=2, rst raised once the ring has taken 4 steps.
        exp_q.push_back(word(1'b0, 1'b0, 1'b0, '0));
        for (int t = 1; t <= 5; t++) exp_q.push_back(word(1'b1, 1'b0, 1'b1, jpat(t - 1)));
        exp_q.push_back(word(1'b0, 1'b0, 1'b0, '0));
        exp_q.push_back(word(1'b0, 1'b0, 1'b0, '0));
        for (int t = 0; t < 8; t++) begin
            @(posedge clk);
            #1;
            start  = (t == 0);
            cycles = CNT_W'(2);
            rst    = (t == 5);
            @(negedge clk);
            check($sformatf("rst_abort t=%0d", t), obs(), exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        run(1, 0, 0, -1);

`ifdef JOHNSON_SEQ_ILLEGAL_CHK_EN
        begin
            int waited;
            @(posedge clk);
            #1;
            start  = 1'b1;
            cycles = CNT_W'(2);
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            force dut.u_ring.q_q = 4'b1010;
            #4;
            release dut.u_ring.q_q;
            @(negedge clk);
            check("err_set", W'({err, phase}), W'({1'b1, 4'b0000}));
            waited = 0;
            while (!done && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            check("err_done_seen", W'(done), W'(1));
            check("err_wait", W'(waited), W'(2 * N * 2 + 1));
            check("err_sticky", W'(err), W'(1));
            @(posedge clk);
            #1;
            start  = 1'b1;
            cycles = CNT_W'(1);
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            check("err_clear", W'({err, busy}), W'(2'b01));
            repeat (2 * N + 2) @(posedge clk);
        end
`else
        check("err_tied", W'(err), W'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
